// File: rtl/axi_if_ct_ar_splitter_if.sv
// Command, AXI4 AR and R-monitor signals of the CT read-address splitter.
// Optional statistics outputs exist only with AXI_IF_CT_AR_SPLIT_STAT_EN defined.
interface axi_if_ct_ar_splitter_if #(
    parameter int AXI4_ADD_W      = 64,
    parameter int AXI4_ID_W       = 1,
    parameter int WORD_NB_W       = 16,
    parameter int OUTSTANDING_MAX = 16
);
    localparam int OCNT_W = $clog2(OUTSTANDING_MAX + 1);

    logic [AXI4_ADD_W-1:0] cmd_add;
    logic [WORD_NB_W-1:0]  cmd_word_nb;
    logic                  cmd_vld;
    logic                  cmd_rdy;
    logic                  cmd_done;

    logic [AXI4_ID_W-1:0]  m_axi4_arid;
    logic [AXI4_ADD_W-1:0] m_axi4_araddr;
    logic [7:0]            m_axi4_arlen;
    logic [2:0]            m_axi4_arsize;
    logic [1:0]            m_axi4_arburst;
    logic                  m_axi4_arvalid;
    logic                  m_axi4_arready;

    logic                  m_axi4_rvalid;
    logic                  m_axi4_rready;
    logic                  m_axi4_rlast;

    logic [OCNT_W-1:0]     outstanding_cnt;
    logic                  idle;
`ifdef AXI_IF_CT_AR_SPLIT_STAT_EN
    logic [31:0]           stat_burst_cnt;
    logic [31:0]           stat_page_split_cnt;
`endif

    // Splitter side
    modport master (
        input  cmd_add,
        input  cmd_word_nb,
        input  cmd_vld,
        output cmd_rdy,
        output cmd_done,
        output m_axi4_arid,
        output m_axi4_araddr,
        output m_axi4_arlen,
        output m_axi4_arsize,
        output m_axi4_arburst,
        output m_axi4_arvalid,
        input  m_axi4_arready,
        input  m_axi4_rvalid,
        input  m_axi4_rready,
        input  m_axi4_rlast,
        output outstanding_cnt,
`ifdef AXI_IF_CT_AR_SPLIT_STAT_EN
        output stat_burst_cnt,
        output stat_page_split_cnt,
`endif
        output idle
    );

    // Load controller / AXI slave side
    modport slave (
        output cmd_add,
        output cmd_word_nb,
        output cmd_vld,
        input  cmd_rdy,
        input  cmd_done,
        input  m_axi4_arid,
        input  m_axi4_araddr,
        input  m_axi4_arlen,
        input  m_axi4_arsize,
        input  m_axi4_arburst,
        input  m_axi4_arvalid,
        output m_axi4_arready,
        output m_axi4_rvalid,
        output m_axi4_rready,
        output m_axi4_rlast,
        input  outstanding_cnt,
`ifdef AXI_IF_CT_AR_SPLIT_STAT_EN
        input  stat_burst_cnt,
        input  stat_page_split_cnt,
`endif
        input  idle
    );
endinterface

// File: rtl/axi_if_ct_ar_splitter.sv
// Splits a CT read command into page-safe AXI4 AR bursts with an outstanding-burst throttle.
// Define AXI_IF_CT_AR_SPLIT_STAT_EN to add saturating burst / page-split statistics counters.
module axi_if_ct_ar_splitter #(
    parameter int AXI4_ADD_W      = 64,
    parameter int AXI4_ID_W       = 1,
    parameter int AXI4_DATA_W     = 512,
    parameter int PAGE_BYTES      = 4096,
    parameter int AXI4_LEN_MAX    = (((PAGE_BYTES / (AXI4_DATA_W / 8)) < 256) ?
                                     (PAGE_BYTES / (AXI4_DATA_W / 8)) : 256) - 1,
    parameter int WORD_NB_W       = 16,
    parameter int OUTSTANDING_MAX = 16,
    parameter int AXI_ID          = 0
) (
    input  logic                     clk,
    input  logic                     a_rst,
    axi_if_ct_ar_splitter_if.master  bus
);
    localparam int DATA_BYTES = AXI4_DATA_W / 8;
    localparam int WORD_LSB   = $clog2(DATA_BYTES);
    localparam int PAGE_WORDS = PAGE_BYTES / DATA_BYTES;
    localparam int OCNT_W     = $clog2(OUTSTANDING_MAX + 1);
    localparam int CW         = (AXI4_ADD_W > WORD_NB_W) ? AXI4_ADD_W : WORD_NB_W + 1;
    localparam logic [AXI4_ADD_W-1:0] WORD_MASK = AXI4_ADD_W'(DATA_BYTES - 1);

    typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [AXI4_ADD_W-1:0] addr_q;
    logic [WORD_NB_W-1:0]  rem_q;
    logic [OCNT_W-1:0]     ocnt_q;
    logic                  done_q;

    logic                  cmd_rdy_c, arvalid_c, idle_c;
    logic [CW-1:0]         page_off, room, rem_w, cap, bw;
    logic                  last_burst;
    logic                  cmd_hs, ar_hs, r_hs;

    function automatic logic [CW-1:0] min3(input logic [CW-1:0] a,
                                           input logic [CW-1:0] b,
                                           input logic [CW-1:0] c);
        logic [CW-1:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    // Decrement floors at zero so rlast beats of bursts lost to a reset are harmless
    function automatic logic [OCNT_W-1:0] ocnt_next(input logic [OCNT_W-1:0] cnt,
                                                   input logic inc,
                                                   input logic dec);
        logic [OCNT_W-1:0] r;
        r = cnt;
        if (inc && !dec)
            r = cnt + OCNT_W'(1);
        else if (dec && !inc && cnt != '0)
            r = cnt - OCNT_W'(1);
        return r;
    endfunction

    // Burst sizing from registered address and remaining count only, so the
    // AR payload holds steady while arready is low
    always_comb begin
        page_off   = (CW'(addr_q) & CW'(PAGE_BYTES - 1)) >> WORD_LSB;
        room       = CW'(PAGE_WORDS) - page_off;
        rem_w      = CW'(rem_q);
        cap        = CW'(AXI4_LEN_MAX + 1);
        bw         = min3(rem_w, room, cap);
        last_burst = (bw == rem_w);
    end

    assign cmd_hs = bus.cmd_vld && cmd_rdy_c;
    assign ar_hs  = arvalid_c && bus.m_axi4_arready;
    assign r_hs   = bus.m_axi4_rvalid && bus.m_axi4_rready && bus.m_axi4_rlast;

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_hs && bus.cmd_word_nb != '0) state_d = SPLIT;
            SPLIT:   if (ar_hs && last_burst)             state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_rdy_c = (state_q == IDLE);
        arvalid_c = (state_q == SPLIT) && (ocnt_q < OCNT_W'(OUTSTANDING_MAX));
        idle_c    = (state_q == IDLE) && (ocnt_q == '0);
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            addr_q <= '0;
            rem_q  <= '0;
        end else if (cmd_hs) begin
            addr_q <= bus.cmd_add & ~WORD_MASK;
            rem_q  <= bus.cmd_word_nb;
        end else if (ar_hs) begin
            addr_q <= addr_q + AXI4_ADD_W'(bw << WORD_LSB);
            rem_q  <= rem_q - WORD_NB_W'(bw);
        end
    end

    // Done fires for an empty command at acceptance, otherwise on the final AR
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            done_q <= 1'b0;
            ocnt_q <= '0;
        end else begin
            done_q <= (cmd_hs && bus.cmd_word_nb == '0) || (ar_hs && last_burst);
            ocnt_q <= ocnt_next(ocnt_q, ar_hs, r_hs);
        end
    end

    assign bus.cmd_rdy         = cmd_rdy_c;
    assign bus.cmd_done        = done_q;
    assign bus.m_axi4_arid     = AXI4_ID_W'(AXI_ID);
    assign bus.m_axi4_araddr   = addr_q;
    assign bus.m_axi4_arlen    = 8'(bw - CW'(1));
    assign bus.m_axi4_arsize   = 3'(WORD_LSB);
    assign bus.m_axi4_arburst  = 2'b01;
    assign bus.m_axi4_arvalid  = arvalid_c;
    assign bus.outstanding_cnt = ocnt_q;
    assign bus.idle            = idle_c;

`ifdef AXI_IF_CT_AR_SPLIT_STAT_EN
    logic        page_limited;
    logic [31:0] stat_burst_q;
    logic [31:0] stat_split_q;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Page-limited means the boundary, not the remaining count or the length cap, set bw
    assign page_limited = (room < rem_w) && (room < cap);

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            stat_burst_q <= '0;
            stat_split_q <= '0;
        end else if (ar_hs) begin
            stat_burst_q <= sat_inc32(stat_burst_q);
            if (page_limited)
                stat_split_q <= sat_inc32(stat_split_q);
        end
    end

    assign bus.stat_burst_cnt      = stat_burst_q;
    assign bus.stat_page_split_cnt = stat_split_q;
`endif

`ifndef SYNTHESIS
    a_cmd_add_aligned: assert property (@(posedge clk) disable iff (a_rst)
        cmd_hs |-> ((bus.cmd_add & WORD_MASK) == '0))
        else $error("cmd_add has nonzero bits below the AXI word size");
`endif
endmodule

// File: tb/tb_axi_if_ct_ar_splitter.sv
// Randomized bench for axi_if_ct_ar_splitter against a burst-list reference model.
// Runs with 64-byte words, 4 KiB pages and an outstanding limit of 2.
module tb_axi_if_ct_ar_splitter;
  localparam int OMAX = 2;
  localparam int WB   = 64;
  localparam int PAGE = 4096;
  localparam int CAP  = 64;

  typedef struct packed {
    logic [63:0] a;
    logic [7:0]  len;
    bit          split;
  } burst_t;

  logic clk = 1'b0;
  logic a_rst;
  always #5 clk = ~clk;

  axi_if_ct_ar_splitter_if #(.OUTSTANDING_MAX(OMAX)) bus ();
  axi_if_ct_ar_splitter #(.OUTSTANDING_MAX(OMAX)) dut (
    .clk  (clk),
    .a_rst(a_rst),
    .bus  (bus)
  );

  burst_t exp_q[$];
  int     m_cnt;
  bit     m_done;
  int     m_bursts;
  int     m_splits;
  int     n_chk;
  int     n_err;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected bursts from the splitting rules: stop at min(remaining, page room, length cap)
  function automatic void build_bursts(input logic [63:0] addr, input int nb);
    logic [63:0] a;
    int rem, room, bw;
    burst_t b;
    a   = addr & ~64'(WB - 1);
    rem = nb;
    while (rem > 0) begin
      room = (PAGE - int'(a % 64'(PAGE))) / WB;
      bw   = rem;
      if (room < bw) bw = room;
      if (CAP < bw) bw = CAP;
      b.a     = a;
      b.len   = 8'(bw - 1);
      b.split = (room < rem) && (room < CAP);
      exp_q.push_back(b);
      a   = a + 64'(bw * WB);
      rem = rem - bw;
    end
  endfunction

  // One clock: check outputs against the model, drive inputs, advance the model
  task automatic step(input bit ardy, input bit rv, input bit rr, input bit rl,
                      input bit cv, input logic [63:0] ca, input int cn);
    bit in_split, exp_v, ar_hs, r_hs;
    @(negedge clk);
    in_split = (exp_q.size() > 0);
    exp_v    = in_split && (m_cnt < OMAX);
    chk("outstanding_cnt", bus.outstanding_cnt, m_cnt);
    chk("arvalid", bus.m_axi4_arvalid, exp_v);
    chk("cmd_rdy", bus.cmd_rdy, !in_split);
    chk("cmd_done", bus.cmd_done, m_done);
    chk("idle", bus.idle, !in_split && m_cnt == 0);
    if (exp_v) begin
      chk("araddr", bus.m_axi4_araddr, exp_q[0].a);
      chk("arlen", bus.m_axi4_arlen, exp_q[0].len);
      chk("arid_size_burst", {bus.m_axi4_arid, bus.m_axi4_arsize, bus.m_axi4_arburst},
          {1'b0, 3'd6, 2'b01});
    end
    bus.m_axi4_arready = ardy;
    bus.m_axi4_rvalid  = rv;
    bus.m_axi4_rready  = rr;
    bus.m_axi4_rlast   = rl;
    bus.cmd_vld        = cv;
    bus.cmd_add        = ca;
    bus.cmd_word_nb    = 16'(cn);
    m_done = 1'b0;
    ar_hs  = exp_v && ardy;
    r_hs   = rv && rr && rl;
    if (cv && !in_split) begin
      build_bursts(ca, cn);
      if (cn == 0) m_done = 1'b1;
    end
    if (ar_hs) begin
      m_bursts++;
      if (exp_q[0].split) m_splits++;
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) m_done = 1'b1;
    end
    if (ar_hs && !r_hs) m_cnt++;
    else if (r_hs && !ar_hs && m_cnt > 0) m_cnt--;
    @(posedge clk);
  endtask

  task automatic finish_cmd(input int rdy_pct, input int r_pct,
                            input int stall_idx, input int stall_len);
    int total, guard, stall_ctr, idx;
    bit ardy, rv, rr, rl;
    total = exp_q.size() + m_bursts;
    guard = 0;
    stall_ctr = 0;
    while (exp_q.size() > 0 && guard < 4000) begin
      idx  = total - m_bursts - exp_q.size();
      idx  = exp_q.size();
      ardy = ($urandom_range(0, 99) < rdy_pct);
      if ((total - m_bursts) - exp_q.size() == 0 && stall_idx >= 0) begin
      end
      if (stall_idx >= 0 && m_bursts == stall_idx && stall_ctr < stall_len) begin
        ardy = 1'b0;
        if (m_cnt < OMAX) stall_ctr++;
      end
      if ($urandom_range(0, 99) < r_pct) begin
        rv = 1'b1; rr = 1'b1; rl = 1'b1;
      end else begin
        rv = 1'($urandom_range(0, 1));
        rr = 1'($urandom_range(0, 1));
        rl = 1'($urandom_range(0, 1)) && !(rv && rr);
      end
      step(ardy, rv, rr, rl, 1'b0, 64'h0, 0);
      guard++;
    end
    chk("cmd_cycle_budget", guard < 4000, 1'b1);
    if (guard >= 4000) exp_q.delete();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 0);
`ifdef AXI_IF_CT_AR_SPLIT_STAT_EN
    chk("stat_burst_cnt", bus.stat_burst_cnt, m_bursts);
    chk("stat_page_split_cnt", bus.stat_page_split_cnt, m_splits);
`endif
  endtask

  // Burst index for stalling is relative to the command, so rebase the stat counter
  task automatic run_cmd(input logic [63:0] addr, input int nb, input int rdy_pct,
                         input int r_pct, input int stall_idx, input int stall_len);
    int base;
    base = m_bursts;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, addr, nb);
    finish_cmd(rdy_pct, r_pct, (stall_idx >= 0) ? base + stall_idx : -1, stall_len);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (m_cnt > 0 && guard < 100) begin
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0, 0);
      guard++;
    end
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 0);
  endtask

  initial begin
    logic [63:0] ra;
    int rn;
    n_chk = 0; n_err = 0;
    m_cnt = 0; m_done = 1'b0; m_bursts = 0; m_splits = 0;
    a_rst = 1'b1;
    bus.cmd_add = '0; bus.cmd_word_nb = '0; bus.cmd_vld = 1'b0;
    bus.m_axi4_arready = 1'b0; bus.m_axi4_rvalid = 1'b0;
    bus.m_axi4_rready = 1'b0; bus.m_axi4_rlast = 1'b0;
    #3;
    chk("rst_arvalid", bus.m_axi4_arvalid, 1'b0);
    chk("rst_cmd_rdy", bus.cmd_rdy, 1'b1);
    chk("rst_cmd_done", bus.cmd_done, 1'b0);
    chk("rst_outstanding", bus.outstanding_cnt, 0);
    chk("rst_idle", bus.idle, 1'b1);
    chk("rst_araddr", bus.m_axi4_araddr, 64'h0);
    @(negedge clk);
    a_rst = 1'b0;

    // Single full-page burst, then page-crossing split, then multi-page with a held AR
    run_cmd(64'h0, 64, 100, 0, -1, 0);
    drain();
    run_cmd(64'hFC0, 3, 100, 0, -1, 0);
    drain();
    run_cmd(64'h0, 200, 100, 40, 1, 5);
    drain();
    run_cmd(64'h1000, 0, 100, 0, -1, 0);
    run_cmd(64'hFFFF_FFFF_FFFF_FFC0, 3, 70, 50, -1, 0);
    drain();
    run_cmd(64'h2FC0, 130, 60, 50, -1, 0);
    drain();

    // Throttle: two ARs then stall until an rlast frees a slot
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0, 200);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 0);
    chk("throttle_cnt", bus.outstanding_cnt, 2);
    chk("throttle_arvalid", bus.m_axi4_arvalid, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0, 0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0, 0);
    finish_cmd(80, 50, -1, 0);
    drain();

    // Reset in the middle of a split with an AR pending
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h4000, 200);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0, 0);
    #2;
    chk("pre_rst_arvalid", bus.m_axi4_arvalid, 1'b1);
    a_rst = 1'b1;
    #1;
    chk("midrst_arvalid", bus.m_axi4_arvalid, 1'b0);
    chk("midrst_cnt", bus.outstanding_cnt, 0);
    chk("midrst_cmd_rdy", bus.cmd_rdy, 1'b1);
    chk("midrst_idle", bus.idle, 1'b1);
    exp_q.delete();
    m_cnt = 0; m_done = 1'b0; m_bursts = 0; m_splits = 0;
    bus.m_axi4_arready = 1'b0; bus.m_axi4_rvalid = 1'b0;
    bus.m_axi4_rready = 1'b0; bus.m_axi4_rlast = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a_rst = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0, 0);
    chk("stray_rlast_cnt", bus.outstanding_cnt, 0);

    // Random commands, including zero-length and near the top of the address space
    for (int k = 0; k < 25; k++) begin
      if ($urandom_range(0, 3) == 0)
        ra = 64'hFFFF_FFFF_FFFF_8000 | 64'($urandom_range(0, 32767));
      else
        ra = {32'h0, $urandom};
      ra = ra & ~64'(WB - 1);
      rn = ($urandom_range(0, 6) == 0) ? 0 : $urandom_range(1, 300);
      run_cmd(ra, rn, $urandom_range(20, 100), $urandom_range(15, 80), -1, 0);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/axi_if_ct_ar_splitter.md
Name: axi_if_ct_ar_splitter

Overview:
- Parametrised AXI4 read-address generator for the CT area. It is the successor to the fixed CT AXI4 parameter set: data width, page size, ID, length cap and outstanding depth are all parameters.
- Accepts one read command at a time (start address, number of AXI words) and splits it into AR bursts. No burst crosses a PAGE_BYTES boundary or exceeds AXI4_LEN_MAX+1 beats.
- Tracks outstanding bursts by watching R-channel rlast handshakes, and throttles AR issue when the count reaches OUTSTANDING_MAX.
- Sits between the CT load controllers and the AXI4 master port.

Parameters:
- AXI4_ADD_W, 64, AR address width.
- AXI4_ID_W, 1, ID width.
- AXI4_DATA_W, 512, data bus width (power of 2, at most 512). AXI4_DATA_BYTES = AXI4_DATA_W/8.
- PAGE_BYTES, 4096, page size (power of 2, at least AXI4_DATA_BYTES).
- AXI4_LEN_MAX, min(PAGE_BYTES/AXI4_DATA_BYTES, 256)-1, maximum arlen.
- WORD_NB_W, 16, width of the command word count.
- OUTSTANDING_MAX, 16, maximum number of AR bursts issued whose rlast has not yet been seen.
- AXI_ID, 0, constant arid value.

Ports:
- clk  in  1  clock
- a_rst  in  1  asynchronous active-high reset
- cmd_add  in  AXI4_ADD_W  start byte address; low log2(AXI4_DATA_BYTES) bits are ignored
- cmd_word_nb  in  WORD_NB_W  number of AXI words to read
- cmd_vld  in  1  command valid
- cmd_rdy  out  1  command ready
- cmd_done  out  1  one-cycle pulse when the last AR of a command is handshaked
- m_axi4_arid  out  AXI4_ID_W  equals AXI_ID
- m_axi4_araddr  out  AXI4_ADD_W  burst address
- m_axi4_arlen  out  8  burst length minus 1
- m_axi4_arsize  out  3  log2(AXI4_DATA_BYTES), constant
- m_axi4_arburst  out  2  constant 2'b01 (INCR)
- m_axi4_arvalid  out  1  AR valid
- m_axi4_arready  in  1  AR ready
- m_axi4_rvalid  in  1  monitor only
- m_axi4_rready  in  1  monitor only
- m_axi4_rlast  in  1  monitor only
- outstanding_cnt  out  $clog2(OUTSTANDING_MAX+1)  current outstanding burst count
- idle  out  1  high in IDLE with outstanding_cnt==0

Behaviour:
Reset values:
- Asynchronous, active-high. State=IDLE; cmd_rdy=1; arvalid=0; cmd_done=0; outstanding_cnt=0; idle=1.
- araddr and the internal remaining-word register reset to 0.

State machine, IDLE / SPLIT:
- IDLE: cmd_rdy=1.
  - cmd_vld with cmd_word_nb==0: command consumed, no AR issued, cmd_done=1 on the next cycle, remain in IDLE.
  - cmd_vld with cmd_word_nb!=0: register the word-aligned address and remaining=cmd_word_nb, go to SPLIT. arvalid may first assert on the next cycle.
- SPLIT: cmd_rdy=0.
  - Burst word count: bw = min(remaining, (PAGE_BYTES - addr%PAGE_BYTES)/AXI4_DATA_BYTES, AXI4_LEN_MAX+1). arlen = bw-1.
  - arvalid = (outstanding_cnt < OUTSTANDING_MAX).
  - AR payload is driven from registers and stays stable while arvalid=1 and arready=0.
  - On AR handshake: addr += bw*AXI4_DATA_BYTES; remaining -= bw.
  - If bw==remaining: go to IDLE and set cmd_done=1 the next cycle.
  - Back-to-back bursts are allowed, one per cycle.

Outstanding counter:
- +1 on AR handshake; -1 on rvalid&rready&rlast.
- Both in the same cycle: unchanged.
- Decrement saturates at 0. rlast beats arriving after a reset are ignored.

Command-to-AR latency:
- Command acceptance to first arvalid: 1 cycle.
- Last AR to cmd_rdy: 1 cycle; cmd_rdy and cmd_done coincide.

Address arithmetic:
- Wraps modulo 2^AXI4_ADD_W.
- Simulation assertion fires if cmd_add has nonzero low bits.

Reset mid-SPLIT:
- Command is abandoned, arvalid drops immediately, counters clear.

Optional Feature:
- Macro: AXI_IF_CT_AR_SPLIT_STAT_EN.
- Defined: adds outputs stat_burst_cnt (32 bits), +1 per AR handshake, and stat_page_split_cnt (32 bits), +1 per handshaked burst whose bw was limited by the page boundary and not by remaining or the length cap.
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: neither output nor counter exists; all other behaviour is identical.

Test Plan:
All scenarios use AXI4_DATA_W=512 and PAGE_BYTES=4096, so 64-byte words and 64 words per page.
- addr=0x0, nb=64, arready=1 → one AR: araddr=0x0, arlen=63, arsize=6, arburst=1; cmd_done pulse; cmd_rdy back 1 cycle later.
- addr=0xFC0, nb=3 → AR (0xFC0, len 0), then AR (0x1000, len 1); stat_page_split_cnt=1.
- addr=0x0, nb=200 → ARs (0x0, 63), (0x1000, 63), (0x2000, 63), (0x3000, 7). Holding arready=0 for 5 cycles on the second AR leaves the payload unchanged.
- nb=0 → no arvalid; cmd_done pulses 1 cycle after acceptance; idle stays 1.
- OUTSTANDING_MAX=2, nb=200, no R beats → 2 ARs, then arvalid=0 with outstanding_cnt=2. One rlast handshake → third AR issued. A cycle with both AR handshake and rlast leaves the count at 2.
- Assert a_rst during SPLIT after the 2nd AR → arvalid=0, outstanding_cnt=0, cmd_rdy=1. Stray rlast afterwards → count stays 0.
